// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state encoding, watchdog limit and port-index width helper
// for the SDRAM requester arbiter.
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    GAP     = 3'd4
  } arb_state_t;

  // Cycles of ready=1 tolerated in WAIT_LO before the strobe edge is assumed lost.
  localparam int WD_LIMIT = 4;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_arb_rr_pick.sv
// sdram_arb_rr_pick: combinational round-robin picker; the first request at or
// after ptr (wrapping at NPORTS) wins and is returned one-hot and as an index.
module sdram_arb_rr_pick
  import sdram_arb_pkg::*;
#(
  parameter int NPORTS = 3,
  parameter int IW     = idx_w(NPORTS)
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [NPORTS-1:0] gnt,
  output logic [IW-1:0]     idx
);

  logic [IW:0]   sum_s;
  logic [IW-1:0] pos_s;
  logic          hit_s;
  logic          found_s;

  // Scan ports from ptr upward with wrap-around; first hit claims the grant.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    sum_s   = '0;
    pos_s   = '0;
    hit_s   = 1'b0;
    found_s = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      sum_s      = {1'b0, ptr} + (IW+1)'(i);
      sum_s      = (sum_s >= (IW+1)'(NPORTS)) ? sum_s - (IW+1)'(NPORTS) : sum_s;
      pos_s      = sum_s[IW-1:0];
      hit_s      = req[pos_s] & ~found_s;
      gnt[pos_s] = gnt[pos_s] | hit_s;
      idx        = hit_s ? pos_s : idx;
      found_s    = found_s | hit_s;
    end
  end

endmodule

// File: rtl/sdram_arb.sv
// sdram_arb: shares the single-port SDRAM controller among NPORTS level-request clients.
// Define SDRAM_ARB_PRIO0_EN to give port 0 absolute priority; other ports stay round-robin.
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int NPORTS = 3,
  parameter int AW     = 27
) (
  input  logic                 clk,
  input  logic                 init_n,
  input  logic [NPORTS-1:0]    req_rd,
  input  logic [NPORTS-1:0]    req_we,
  input  logic [NPORTS*AW-1:0] req_addr,
  input  logic [NPORTS*16-1:0] req_din,
  input  logic [NPORTS*2-1:0]  req_wtbt,
  output logic [NPORTS-1:0]    ack,
  output logic [15:0]          rdata,
  output logic [AW-1:0]        ram_addr,
  output logic [15:0]          ram_din,
  output logic [1:0]           ram_wtbt,
  output logic                 ram_we,
  output logic                 ram_rd,
  input  logic                 ram_ready,
  input  logic [15:0]          ram_dout,
  output logic                 busy
);

  localparam int IW  = idx_w(NPORTS);
  localparam int WDW = $clog2(WD_LIMIT);
  localparam logic [NPORTS-1:0] P0_ONEHOT = {{(NPORTS-1){1'b0}}, 1'b1};

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d, gidx_q, gidx_d;
  logic              dir_we_q, dir_we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [15:0]       din_q, din_d, rdata_q, rdata_d;
  logic [1:0]        wtbt_q, wtbt_d;
  logic              we_q, we_d, rd_q, rd_d, busy_q, busy_d;
  logic [NPORTS-1:0] ack_q, ack_d;
  logic [WDW-1:0]    wd_q, wd_d;

  logic [NPORTS-1:0] req_any_s, pick_req_s, pick_gnt_s, gnt_s;
  logic [IW-1:0]     pick_idx_s, grant_idx_s, ptr_next_s;

  assign req_any_s  = req_rd | req_we;
  assign ptr_next_s = (gidx_q == IW'(NPORTS-1)) ? '0 : gidx_q + IW'(1);

`ifdef SDRAM_ARB_PRIO0_EN
  assign pick_req_s  = req_any_s & ~P0_ONEHOT;
  assign gnt_s       = req_any_s[0] ? P0_ONEHOT : pick_gnt_s;
  assign grant_idx_s = req_any_s[0] ? '0 : pick_idx_s;
`else
  assign pick_req_s  = req_any_s;
  assign gnt_s       = pick_gnt_s;
  assign grant_idx_s = pick_idx_s;
`endif

  sdram_arb_rr_pick #(
    .NPORTS (NPORTS),
    .IW     (IW)
  ) u_pick (
    .req (pick_req_s),
    .ptr (ptr_q),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s)
  );

  // Next-state logic: grant, strobe issue, ready low/high tracking, watchdog reissue.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    dir_we_d = dir_we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    wtbt_d   = wtbt_q;
    rdata_d  = rdata_q;
    we_d     = we_q;
    rd_d     = rd_q;
    busy_d   = busy_q;
    ack_d    = '0;
    wd_d     = wd_q;
    case (state_q)
      IDLE: begin
        if (ram_ready && (|req_any_s)) begin
          gidx_d   = grant_idx_s;
          dir_we_d = |(gnt_s & req_we);
          addr_d   = req_addr[int'(grant_idx_s)*AW +: AW];
          din_d    = req_din[int'(grant_idx_s)*16 +: 16];
          wtbt_d   = req_wtbt[int'(grant_idx_s)*2 +: 2];
          busy_d   = 1'b1;
          state_d  = ISSUE;
        end else begin
          busy_d   = 1'b0;
        end
      end
      ISSUE: begin
        we_d    = dir_we_q;
        rd_d    = ~dir_we_q;
        wd_d    = '0;
        state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!ram_ready) begin
          state_d = WAIT_HI;
        end else if (wd_q == WDW'(WD_LIMIT-1)) begin
          // Controller never acknowledged the edge: drop for a cycle and retry.
          we_d    = 1'b0;
          rd_d    = 1'b0;
          state_d = ISSUE;
        end else begin
          wd_d    = wd_q + WDW'(1);
        end
      end
      WAIT_HI: begin
        if (ram_ready) begin
          rdata_d       = dir_we_q ? rdata_q : ram_dout;
          ack_d[gidx_q] = 1'b1;
          we_d          = 1'b0;
          rd_d          = 1'b0;
`ifdef SDRAM_ARB_PRIO0_EN
          ptr_d         = (gidx_q == '0) ? ptr_q : ptr_next_s;
`else
          ptr_d         = ptr_next_s;
`endif
          state_d       = GAP;
        end else begin
          state_d       = WAIT_HI;
        end
      end
      GAP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        we_d    = 1'b0;
        rd_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gidx_q   <= '0;
      dir_we_q <= 1'b0;
      addr_q   <= '0;
      din_q    <= 16'h0000;
      wtbt_q   <= 2'b00;
      rdata_q  <= 16'h0000;
      we_q     <= 1'b0;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      dir_we_q <= dir_we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      wtbt_q   <= wtbt_d;
      rdata_q  <= rdata_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      wd_q     <= wd_d;
    end
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign ram_addr = addr_q;
  assign ram_din  = din_q;
  assign ram_wtbt = wtbt_q;
  assign ram_we   = we_q;
  assign ram_rd   = rd_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sdram_arb.sv
// tb_sdram_arb: directed bench with a behavioural SDRAM controller model and an
// ack-driven scoreboard; expected transactions are queued in hand-computed grant order.
module tb_sdram_arb;

  localparam int NPORTS = 3;
  localparam int AW     = 27;

  logic                 clk = 1'b0;
  logic                 init_n;
  logic [NPORTS-1:0]    req_rd, req_we;
  logic [NPORTS*AW-1:0] req_addr;
  logic [NPORTS*16-1:0] req_din;
  logic [NPORTS*2-1:0]  req_wtbt;
  logic [NPORTS-1:0]    ack;
  logic [15:0]          rdata;
  logic [AW-1:0]        ram_addr;
  logic [15:0]          ram_din;
  logic [1:0]           ram_wtbt;
  logic                 ram_we, ram_rd;
  logic                 ram_ready = 1'b0;
  logic [15:0]          ram_dout  = 16'h0000;
  logic                 busy;

  always #5 clk = ~clk;

  sdram_arb #(.NPORTS(NPORTS), .AW(AW)) dut (
    .clk(clk), .init_n(init_n),
    .req_rd(req_rd), .req_we(req_we), .req_addr(req_addr),
    .req_din(req_din), .req_wtbt(req_wtbt),
    .ack(ack), .rdata(rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_wtbt(ram_wtbt),
    .ram_we(ram_we), .ram_rd(ram_rd), .ram_ready(ram_ready), .ram_dout(ram_dout),
    .busy(busy)
  );

  typedef struct {
    int          port;
    bit          we;
    logic [AW-1:0] addr;
    logic [15:0] din;
    logic [1:0]  wtbt;
    logic [15:0] rdat;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_rd = 16'h0000;

  // controller model state
  logic [15:0]   mem [int];
  bit            hold_init  = 1'b1;
  bit            delay_once = 1'b0;
  int            svc_cycles = 3;
  int            phase = 0;
  int            cnt   = 0;
  bit            prev_stb = 1'b0;
  int            edges = 0;
  logic [AW-1:0] cap_addr = '0;
  logic [15:0]   cap_din  = 16'h0000;
  logic [1:0]    cap_wtbt = 2'b00;
  bit            cap_we   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input int k);
    return mem.exists(k) ? mem[k] : 16'h0000;
  endfunction

  // Controller model: ready drops one cycle after a strobe edge, returns after svc_cycles.
  always @(negedge clk) begin
    logic [15:0] old;
    if (hold_init) begin
      ram_ready = 1'b0;
      phase     = 0;
    end else begin
      case (phase)
        0: begin
          ram_ready = 1'b1;
          if ((ram_rd | ram_we) && !prev_stb) begin
            edges++;
            cap_addr = ram_addr; cap_din = ram_din; cap_wtbt = ram_wtbt; cap_we = ram_we;
            cnt = delay_once ? 6 : 1;
            delay_once = 1'b0;
            phase = 1;
          end
        end
        1: begin
          if (!(ram_rd | ram_we)) phase = 0;
          else begin
            cnt--;
            if (cnt == 0) begin ram_ready = 1'b0; cnt = svc_cycles; phase = 2; end
          end
        end
        2: begin
          cnt--;
          if (cnt == 0) begin
            old = mem_rd(int'(cap_addr));
            if (cap_we)
              mem[int'(cap_addr)] = {cap_wtbt[1] ? cap_din[15:8] : old[15:8],
                                     cap_wtbt[0] ? cap_din[7:0]  : old[7:0]};
            else
              ram_dout = old;
            ram_ready = 1'b1;
            phase = 0;
          end
        end
        default: phase = 0;
      endcase
    end
    prev_stb = ram_rd | ram_we;
  end

  // Scoreboard monitor: every ack pops one expected transaction.
  always @(negedge clk) begin
    exp_t e;
    if (ack != '0) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack: got ack=%b expected none", ack);
      end else begin
        e = exp_q.pop_front();
        check("ack_port", 32'(ack), 32'(1) << e.port);
        check("dir_we", 32'(cap_we), 32'(e.we));
        check("ctrl_addr", 32'(cap_addr), 32'(e.addr));
        check("addr_hold", 32'(ram_addr), 32'(e.addr));
        check("ctrl_wtbt", 32'(cap_wtbt), 32'(e.wtbt));
        check("strobe_low_at_ack", 32'({ram_we, ram_rd}), 32'(0));
        if (e.we) begin
          check("ctrl_din", 32'(cap_din), 32'(e.din));
          check("rdata_held", 32'(rdata), 32'(last_rd));
        end else begin
          check("rdata", 32'(rdata), 32'(e.rdat));
          last_rd = e.rdat;
        end
      end
    end
  end

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] w);
    req_addr[p*AW +: AW] = a;
    req_din[p*16 +: 16]  = d;
    req_wtbt[p*2 +: 2]   = w;
  endtask

  task automatic push(input int p, input bit we, input logic [AW-1:0] a, input logic [15:0] d,
                      input logic [1:0] w, input logic [15:0] r);
    exp_t e;
    e.port = p; e.we = we; e.addr = a; e.din = d; e.wtbt = w; e.rdat = r;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    init_n = 1'b0;
    repeat (n) @(negedge clk);
    init_n  = 1'b1;
    last_rd = 16'h0000;
  endtask

  task automatic wait_ack(input int p, input int budget, input string name);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      got = ack[p];
    end
    req_rd[p] = 1'b0;
    req_we[p] = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s: got no ack on port %0d expected ack within %0d cycles", name, p, budget);
      exp_q.delete();
    end
  endtask

  task automatic xfer(input int p, input bit we, input logic [AW-1:0] a, input logic [15:0] d,
                      input logic [1:0] w, input logic [15:0] r, input string name);
    set_port(p, a, d, w);
    push(p, we, a, d, w, r);
    if (we) req_we[p] = 1'b1; else req_rd[p] = 1'b1;
    wait_ack(p, 300, name);
    @(negedge clk);
  endtask

  // Concurrent writers: port p stays requesting until it has collected left[p] acks.
  task automatic run_multi(input int n0, input int n1, input int n2, input string name);
    int left [NPORTS];
    bit done = 1'b0;
    left[0] = n0; left[1] = n1; left[2] = n2;
    for (int p = 0; p < NPORTS; p++) req_we[p] = (left[p] > 0);
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      done = 1'b1;
      for (int p = 0; p < NPORTS; p++) begin
        if (ack[p] && left[p] > 0) begin
          left[p]--;
          if (left[p] == 0) req_we[p] = 1'b0;
        end
        if (left[p] > 0) done = 1'b0;
      end
    end
    req_we = '0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s: got incomplete grant sequence expected all acks within budget", name);
      exp_q.delete();
    end
    @(negedge clk);
    #1;
    check({name, "_drained"}, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    int e0;
    int stb_seen;
    bit got;
    req_rd = '0; req_we = '0; req_addr = '0; req_din = '0; req_wtbt = '0;
    mem[int'(27'h0000100)] = 16'h1234;
    mem[int'(27'h0000010)] = 16'h1100;

    // 1: reset state, no strobe while controller is not ready, single read
    init_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_ack", 32'(ack), 32'(0));
    check("rst_strobes", 32'({ram_we, ram_rd}), 32'(0));
    check("rst_rdata", 32'(rdata), 32'(0));
    check("rst_ram_addr", 32'(ram_addr), 32'(0));
    check("rst_ram_din_wtbt", 32'({ram_din, ram_wtbt}), 32'(0));
    init_n = 1'b1;
    set_port(1, 27'h0000100, 16'h0000, 2'b11);
    push(1, 1'b0, 27'h0000100, 16'h0000, 2'b11, 16'h1234);
    req_rd[1] = 1'b1;
    stb_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (ram_rd | ram_we | busy) stb_seen++;
    end
    check("no_strobe_before_ready", 32'(stb_seen), 32'(0));
    e0 = edges;
    hold_init = 1'b0;
    wait_ack(1, 300, "t1_ack");
    @(negedge clk);
    check("t1_rd_edges", 32'(edges - e0), 32'(1));

    // 2: three continuous writers, round-robin from pointer 0
    do_reset(2);
    set_port(0, 27'h0000200, 16'hA000, 2'b11);
    set_port(1, 27'h0000300, 16'hB000, 2'b11);
    set_port(2, 27'h0000400, 16'hC000, 2'b11);
    push(0, 1'b1, 27'h0000200, 16'hA000, 2'b11, 16'h0000);
    push(1, 1'b1, 27'h0000300, 16'hB000, 2'b11, 16'h0000);
    push(2, 1'b1, 27'h0000400, 16'hC000, 2'b11, 16'h0000);
    push(0, 1'b1, 27'h0000200, 16'hA000, 2'b11, 16'h0000);
    run_multi(2, 1, 1, "t2_rr");

    // 3: byte-enable passthrough and merge
    xfer(2, 1'b1, 27'h0000010, 16'h55AA, 2'b01, 16'h0000, "t3_wr");
    xfer(0, 1'b0, 27'h0000010, 16'h0000, 2'b11, 16'h11AA, "t3_rd");

    // 4: missed edge -> watchdog reissue, then a read-hit with one-cycle ready low
    delay_once = 1'b1;
    e0 = edges;
    xfer(1, 1'b1, 27'h0000020, 16'h7777, 2'b11, 16'h0000, "t4_wd");
    check("t4_wd_edges", 32'(edges - e0), 32'(2));
    svc_cycles = 1;
    xfer(2, 1'b0, 27'h0000020, 16'h0000, 2'b10, 16'h7777, "t4_hit");
    svc_cycles = 3;

    // 5: reset while waiting for ready to return
    svc_cycles = 6;
    set_port(2, 27'h0000100, 16'h0000, 2'b11);
    req_rd[2] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      #1;
      got = busy && !ram_ready;
    end
    check("t5_reached_wait", 32'(got), 32'(1));
    @(negedge clk);
    init_n = 1'b0;
    req_rd[2] = 1'b0;
    @(negedge clk);
    check("t5_rd_low", 32'(ram_rd), 32'(0));
    check("t5_busy_low", 32'(busy), 32'(0));
    check("t5_no_ack", 32'(ack), 32'(0));
    check("t5_rdata_cleared", 32'(rdata), 32'(0));
    init_n  = 1'b1;
    last_rd = 16'h0000;
    repeat (12) @(negedge clk);
    svc_cycles = 3;

    // 6: port 0 re-requests after every ack while port 1 waits
    do_reset(2);
    set_port(0, 27'h0000600, 16'hD000, 2'b11);
    set_port(1, 27'h0000700, 16'hE000, 2'b11);
`ifdef SDRAM_ARB_PRIO0_EN
    push(0, 1'b1, 27'h0000600, 16'hD000, 2'b11, 16'h0000);
    push(0, 1'b1, 27'h0000600, 16'hD000, 2'b11, 16'h0000);
    push(0, 1'b1, 27'h0000600, 16'hD000, 2'b11, 16'h0000);
    push(1, 1'b1, 27'h0000700, 16'hE000, 2'b11, 16'h0000);
`else
    push(0, 1'b1, 27'h0000600, 16'hD000, 2'b11, 16'h0000);
    push(1, 1'b1, 27'h0000700, 16'hE000, 2'b11, 16'h0000);
    push(0, 1'b1, 27'h0000600, 16'hD000, 2'b11, 16'h0000);
    push(0, 1'b1, 27'h0000600, 16'hD000, 2'b11, 16'h0000);
`endif
    run_multi(3, 1, 0, "t6_prio");

    repeat (5) @(negedge clk);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
